predictor_scheduler: RTL and testbench

PREDICTOR_SCHEDULER -- requirements
Module: predictor_scheduler

---
 rtl/predictor_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_predictor_scheduler.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/predictor_scheduler.sv
// predictor_scheduler
// Table of 2**IDX_W two-bit saturating branch counters behind one shared
// access port. Each cycle the port goes to exactly one of: a lookup from one
// of two round-robin requesters, a write that retires the head of an
// in-order update FIFO, or nobody. Lookups read the stored table only, so an
// update that is still queued has no effect on a prediction.
//
// Optional feature: define PREDICTOR_SCHEDULER_STATS_EN to add the
// saturating counters stat_lookups (grants) and stat_stalls (cycles in which
// a request was pending but not granted). The core behaves the same either way.

module predictor_scheduler #(
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [IDX_W-1:0] idx0,
  input  logic [IDX_W-1:0] idx1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             pred_valid,
  output logic             pred_id,
  output logic             prediction,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready
`ifdef PREDICTOR_SCHEDULER_STATS_EN
  ,
  output logic [15:0]      stat_lookups,
  output logic [15:0]      stat_stalls
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Who owns the single table port in the current cycle.
  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_LOOKUP,
    PORT_UPDATE
  } port_owner_t;

  // Counter table and update FIFO storage.
  logic [1:0]       table_q    [ENTRIES];
  logic [IDX_W-1:0] fifo_idx   [FIFO_DEPTH];
  logic             fifo_taken [FIFO_DEPTH];

  // FIFO bookkeeping. Depth is a power of two so the pointers wrap naturally.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Round-robin memory: 1 means requester 1 was granted last, so requester 0
  // wins the next tie.
  logic             rr_last;

  // Goes high one cycle after reset releases; holds upd_ready low until then.
  logic             ready_en;

  // Registered prediction result.
  logic             pv_q;
  logic             pid_q;
  logic             pred_q;

  port_owner_t      owner;
  logic             gnt0_c;
  logic             gnt1_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic             any_req;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [1:0]       head_ctr;
  logic [1:0]       head_ctr_next;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign any_req    = req0 | req1;

  // Port arbitration: a full queue forces a write, otherwise lookups win over
  // draining, and ties between requesters alternate.
  always_comb begin
    owner  = PORT_IDLE;
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      if (fifo_full) begin
        owner = PORT_UPDATE;
      end else if (any_req) begin
        owner = PORT_LOOKUP;
        if (req0 && req1) begin
          if (rr_last) begin
            gnt0_c = 1'b1;
          end else begin
            gnt1_c = 1'b1;
          end
        end else if (req0) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
      end else if (!fifo_empty) begin
        owner = PORT_UPDATE;
      end
    end
  end

  assign lookup_idx = gnt1_c ? idx1 : idx0;
  assign upd_ready  = ready_en & ~fifo_full & ~rst;
  assign push       = upd_valid & upd_ready;
  assign pop        = (owner == PORT_UPDATE);

  assign head_idx   = fifo_idx[rd_ptr];
  assign head_taken = fifo_taken[rd_ptr];
  assign head_ctr   = table_q[head_idx];

  // Saturating step for the counter addressed by the queue head.
  always_comb begin
    head_ctr_next = head_ctr;
    if (head_taken) begin
      if (head_ctr != 2'b11) begin
        head_ctr_next = head_ctr + 2'b01;
      end
    end else begin
      if (head_ctr != 2'b00) begin
        head_ctr_next = head_ctr - 2'b01;
      end
    end
  end

  // Counter table: all entries go strong-taken on reset; one write per pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= 2'b11;
      end
    end else if (pop) begin
      table_q[head_idx] <= head_ctr_next;
    end
  end

  // FIFO payload storage; contents are don't-care while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]   <= upd_idx;
      fifo_taken[wr_ptr] <= upd_taken;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Round-robin pointer moves only when a grant is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (gnt0_c) begin
      rr_last <= 1'b0;
    end else if (gnt1_c) begin
      rr_last <= 1'b1;
    end
  end

  // Ready enable: low through reset, high from the second post-reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Prediction register: captures the MSB of the counter read by a lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q   <= 1'b0;
      pid_q  <= 1'b0;
      pred_q <= 1'b0;
    end else begin
      pv_q <= (owner == PORT_LOOKUP);
      if (owner == PORT_LOOKUP) begin
        pid_q  <= gnt1_c;
        pred_q <= table_q[lookup_idx][1];
      end
    end
  end

  assign gnt0       = gnt0_c;
  assign gnt1       = gnt1_c;
  assign pred_valid = pv_q & ~rst;
  assign pred_id    = pid_q & ~rst;
  assign prediction = pred_q & ~rst;

`ifdef PREDICTOR_SCHEDULER_STATS_EN
  logic [15:0] lookups_q;
  logic [15:0] stalls_q;

  // Saturating activity counters: grants and request-but-no-grant cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q <= '0;
      stalls_q  <= '0;
    end else begin
      if ((gnt0_c || gnt1_c) && (lookups_q != 16'hFFFF)) begin
        lookups_q <= lookups_q + 16'd1;
      end
      if (any_req && !gnt0_c && !gnt1_c && (stalls_q != 16'hFFFF)) begin
        stalls_q <= stalls_q + 16'd1;
      end
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_predictor_scheduler.sv
// tb_predictor_scheduler
// Self-checking bench for predictor_scheduler. A transaction-level model
// (counter array plus an update queue) predicts grants, readiness and
// predictions; directed scenarios add hand-computed expectations.
// Define PREDICTOR_SCHEDULER_STATS_EN to also check the statistics outputs.

module tb_predictor_scheduler;

  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IDX_W;

  logic             clk;
  logic             rst;
  logic             req0, req1;
  logic [IDX_W-1:0] idx0, idx1;
  logic             gnt0, gnt1;
  logic             pred_valid, pred_id, prediction;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
`ifdef PREDICTOR_SCHEDULER_STATS_EN
  logic [15:0]      stat_lookups;
  logic [15:0]      stat_stalls;
`endif

  int checks   = 0;
  int failures = 0;

  predictor_scheduler #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .idx0       (idx0),
    .idx1       (idx1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .pred_valid (pred_valid),
    .pred_id    (pred_id),
    .prediction (prediction),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready)
`ifdef PREDICTOR_SCHEDULER_STATS_EN
    ,
    .stat_lookups (stat_lookups),
    .stat_stalls  (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct { int idx; bit taken; } upd_t;
  int   mctr [NENT];
  upd_t mq [$];
  bit   m_last;
  bit   m_rdy;
  bit   exp_pv, exp_pid, exp_pred;
  bit   e_g0, e_g1, e_ready;
  int   m_lookups, m_stalls;

  // Expected combinational outputs for the current cycle's inputs.
  task automatic model_eval();
    bit full;
    full    = (mq.size() == DEPTH);
    e_ready = !rst && m_rdy && !full;
    e_g0    = 1'b0;
    e_g1    = 1'b0;
    if (!rst && !full) begin
      if (req0 && req1) begin
        if (m_last) e_g0 = 1'b1; else e_g1 = 1'b1;
      end else if (req0) begin
        e_g0 = 1'b1;
      end else if (req1) begin
        e_g1 = 1'b1;
      end
    end
  endtask

  // Apply one clock edge to the model.
  task automatic model_commit();
    bit   full;
    bit   do_pop;
    upd_t h;
    upd_t u;
    if (rst) begin
      foreach (mctr[i]) mctr[i] = 3;
      mq.delete();
      m_last = 1'b1; m_rdy = 1'b0;
      exp_pv = 1'b0; exp_pid = 1'b0; exp_pred = 1'b0;
      m_lookups = 0; m_stalls = 0;
      return;
    end
    full   = (mq.size() == DEPTH);
    do_pop = full || (!(req0 || req1) && mq.size() > 0);
    exp_pv = e_g0 || e_g1;
    if (exp_pv) begin
      exp_pid  = e_g1;
      exp_pred = (mctr[e_g1 ? idx1 : idx0] >= 2);
      if (m_lookups < 65535) m_lookups++;
    end else if (req0 || req1) begin
      if (m_stalls < 65535) m_stalls++;
    end
    if (do_pop) begin
      h = mq.pop_front();
      if (h.taken) mctr[h.idx] = (mctr[h.idx] == 3) ? 3 : mctr[h.idx] + 1;
      else         mctr[h.idx] = (mctr[h.idx] == 0) ? 0 : mctr[h.idx] - 1;
    end
    if (upd_valid && e_ready) begin
      u.idx = int'(upd_idx); u.taken = upd_taken;
      mq.push_back(u);
    end
    m_rdy = 1'b1;
    if (e_g0) m_last = 1'b0; else if (e_g1) m_last = 1'b1;
  endtask

  task automatic to_neg();
    @(negedge clk);
    model_eval();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin to_neg(); to_pos(); end
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; idx0 = '0; idx1 = '0;
    upd_valid = 0; upd_idx = '0; upd_taken = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    idle(2);
    rst = 0;
    idle(2);
  endtask

  // Offer one update until accepted (bounded).
  task automatic push_update(input int idx, input bit tk);
    bit done;
    done = 0;
    upd_valid = 1; upd_idx = IDX_W'(idx); upd_taken = tk;
    for (int c = 0; c < 20 && !done; c++) begin
      to_neg(); done = e_ready; to_pos();
    end
    upd_valid = 0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL push_timeout: got not accepted, expected accepted within 20 cycles");
    end
  endtask

  // Issue a lookup and sample the grant and the following prediction.
  task automatic lookup_probe(input bit id, input int idx,
                              output bit g, output bit pv, output bit pid, output bit pr);
    req0 = !id; req1 = id; idx0 = IDX_W'(idx); idx1 = IDX_W'(idx);
    to_neg(); g = id ? gnt1 : gnt0; to_pos();
    req0 = 0; req1 = 0;
    to_neg(); pv = pred_valid; pid = pred_id; pr = prediction; to_pos();
  endtask

  task automatic test_reset();
    rst = 1;
    for (int c = 0; c < 3; c++) begin
      req0 = 1'($urandom); req1 = 1'($urandom); upd_valid = 1'($urandom);
      idx0 = IDX_W'($urandom); idx1 = IDX_W'($urandom);
      to_neg();
      checks++;
      if ({gnt0, gnt1, pred_valid, pred_id, prediction, upd_ready} !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs: got %b expected 000000",
                 {gnt0, gnt1, pred_valid, pred_id, prediction, upd_ready});
      end
      to_pos();
    end
    clear_inputs();
    rst = 0;
    to_neg();
    checks++;
    if (upd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_first_cycle: got %b expected 0", upd_ready);
    end
    to_pos();
    to_neg();
    checks++;
    if (upd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_rise: got %b expected 1", upd_ready);
    end
    to_pos();
  endtask

  task automatic test_lookup();
    req0 = 1; idx0 = 4'd5;
    to_neg();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL basic_grant: got %b expected 10", {gnt0, gnt1});
    end
    to_pos();
    req0 = 0;
    to_neg();
    checks++;
    if ({pred_valid, pred_id, prediction} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL basic_pred: got %b expected 101", {pred_valid, pred_id, prediction});
    end
    to_pos();
  endtask

  task automatic test_round_robin();
    bit exp_g [4] = '{0, 1, 0, 1};
    apply_reset();
    req0 = 1; req1 = 1; idx0 = 4'd1; idx1 = 4'd2;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin req0 = 0; req1 = 0; end
      to_neg();
      if (c < 4) begin
        checks++;
        if ({gnt0, gnt1} !== (exp_g[c] ? 2'b01 : 2'b10)) begin
          failures++;
          $display("[TB] FAIL rr_grant%0d: got %b expected %b", c, {gnt0, gnt1},
                   exp_g[c] ? 2'b01 : 2'b10);
        end
      end
      if (c > 0) begin
        checks++;
        if ({pred_valid, pred_id} !== {1'b1, exp_g[c-1]}) begin
          failures++;
          $display("[TB] FAIL rr_pred_id%0d: got %b expected %b", c,
                   {pred_valid, pred_id}, {1'b1, exp_g[c-1]});
        end
      end
      to_pos();
    end
  endtask

  task automatic test_saturate();
    bit g, pv, pid, pr;
    bit exp_pr [3] = '{0, 0, 1};
    apply_reset();
    for (int k = 0; k < 3; k++) push_update(2, 0);
    idle(6);
    lookup_probe(1, 2, g, pv, pid, pr);
    checks++;
    if ({g, pv, pid, pr} !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL sat_zero: got %b expected 1110", {g, pv, pid, pr});
    end
    // 4th not-taken holds at 0; then two taken steps give 1 then 2.
    for (int s = 0; s < 3; s++) begin
      push_update(2, s != 0);
      idle(3);
      lookup_probe(0, 2, g, pv, pid, pr);
      checks++;
      if ({g, pv, pr} !== {2'b11, exp_pr[s]}) begin
        failures++;
        $display("[TB] FAIL sat_step%0d: got %b expected %b", s, {g, pv, pr}, {2'b11, exp_pr[s]});
      end
    end
  endtask

  task automatic test_full_stall();
    int s_idx [8] = '{5, 5, 5, 0, 0, 1, 1, 2};
    bit s_tk  [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int pr_idx [5] = '{5, 0, 1, 2, 3};
    bit pr_exp [5] = '{0, 0, 0, 1, 1};
    int k, stalls_dut, stalls_exp;
    bit adv, g, pv, pid, pr;
    apply_reset();
    k = 0; stalls_dut = 0; stalls_exp = 0;
    req0 = 1; idx0 = 4'd9;
    for (int c = 0; c < 60 && (k < 8 || c < 40); c++) begin
      if (k < 8) begin
        upd_valid = 1; upd_idx = IDX_W'(s_idx[k]); upd_taken = s_tk[k];
      end else begin
        upd_valid = 0;
      end
      if (c >= 30) req0 = 0;
      to_neg();
      checks += 3;
      if (gnt0 !== e_g0) begin
        failures++; $display("[TB] FAIL stall_gnt0 c%0d: got %b expected %b", c, gnt0, e_g0);
      end
      if (upd_ready !== e_ready) begin
        failures++; $display("[TB] FAIL stall_ready c%0d: got %b expected %b", c, upd_ready, e_ready);
      end
      if (pred_valid !== exp_pv) begin
        failures++; $display("[TB] FAIL stall_pv c%0d: got %b expected %b", c, pred_valid, exp_pv);
      end
      if (req0 && !e_g0) stalls_exp++;
      if (req0 && !gnt0) stalls_dut++;
      adv = upd_valid && e_ready;
      to_pos();
      if (adv) k++;
    end
    upd_valid = 0; req0 = 0;
    checks += 2;
    if (k != 8) begin
      failures++; $display("[TB] FAIL stall_pushes: got %0d expected 8", k);
    end
    if (stalls_dut != stalls_exp) begin
      failures++; $display("[TB] FAIL stall_count: got %0d expected %0d", stalls_dut, stalls_exp);
    end
`ifdef PREDICTOR_SCHEDULER_STATS_EN
    to_neg();
    checks += 2;
    if (stat_stalls !== 16'(m_stalls)) begin
      failures++; $display("[TB] FAIL stat_stalls: got %0d expected %0d", stat_stalls, m_stalls);
    end
    if (stat_lookups !== 16'(m_lookups)) begin
      failures++; $display("[TB] FAIL stat_lookups: got %0d expected %0d", stat_lookups, m_lookups);
    end
    to_pos();
`endif
    for (int p = 0; p < 5; p++) begin
      lookup_probe(0, pr_idx[p], g, pv, pid, pr);
      checks++;
      if ({g, pv, pr} !== {2'b11, pr_exp[p]}) begin
        failures++;
        $display("[TB] FAIL drain_idx%0d: got %b expected %b", pr_idx[p], {g, pv, pr}, {2'b11, pr_exp[p]});
      end
    end
  endtask

  task automatic test_reset_mid();
    bit g, pv, pid, pr;
    int bad;
    apply_reset();
    req0 = 1; idx0 = 4'd7; upd_valid = 1; upd_idx = 4'd7; upd_taken = 0;
    idle(2);
    rst = 1; upd_valid = 0;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      checks++;
      if ({pred_valid, upd_ready, gnt0} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL midreset_out%0d: got %b expected 000", c, {pred_valid, upd_ready, gnt0});
      end
      to_pos();
    end
    rst = 0; req0 = 0;
    to_neg();
    checks++;
    if (pred_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_pv: got %b expected 0", pred_valid);
    end
    to_pos();
    idle(2);
    bad = 0;
    for (int i = 0; i < NENT; i++) begin
      lookup_probe(i[0], i, g, pv, pid, pr);
      if ({g, pv, pr} !== 3'b111) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("[TB] FAIL midreset_table: got %0d bad entries expected 0", bad);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(req0 && !e_g0)) begin req0 = 1'($urandom); idx0 = IDX_W'($urandom_range(0, 7)); end
      if (!(req1 && !e_g1)) begin req1 = 1'($urandom); idx1 = IDX_W'($urandom_range(0, 7)); end
      if ($urandom_range(0, 3) == 0) begin req0 = 0; req1 = 0; end
      upd_valid = ($urandom_range(0, 2) != 0);
      upd_idx   = IDX_W'($urandom_range(0, 7));
      upd_taken = 1'($urandom);
      to_neg();
      checks += 4;
      if (gnt0 !== e_g0) begin
        failures++; $display("[TB] FAIL rnd_gnt0 c%0d: got %b expected %b", c, gnt0, e_g0);
      end
      if (gnt1 !== e_g1) begin
        failures++; $display("[TB] FAIL rnd_gnt1 c%0d: got %b expected %b", c, gnt1, e_g1);
      end
      if (upd_ready !== e_ready) begin
        failures++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", c, upd_ready, e_ready);
      end
      if (pred_valid !== (exp_pv && !rst)) begin
        failures++; $display("[TB] FAIL rnd_pv c%0d: got %b expected %b", c, pred_valid, exp_pv && !rst);
      end
      if (exp_pv && !rst) begin
        checks++;
        if ({pred_id, prediction} !== {exp_pid, exp_pred}) begin
          failures++;
          $display("[TB] FAIL rnd_pred c%0d: got %b expected %b", c, {pred_id, prediction}, {exp_pid, exp_pred});
        end
      end
      to_pos();
    end
    clear_inputs(); rst = 0;
`ifdef PREDICTOR_SCHEDULER_STATS_EN
    to_neg();
    checks += 2;
    if (stat_stalls !== 16'(m_stalls)) begin
      failures++; $display("[TB] FAIL rnd_stat_stalls: got %0d expected %0d", stat_stalls, m_stalls);
    end
    if (stat_lookups !== 16'(m_lookups)) begin
      failures++; $display("[TB] FAIL rnd_stat_lookups: got %0d expected %0d", stat_lookups, m_lookups);
    end
    to_pos();
`endif
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    model_commit();
    @(posedge clk); #1;
    test_reset();
    test_lookup();
    test_round_robin();
    test_saturate();
    test_full_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
